// File: rtl/ram_dp_clr.sv
// Simple-dual-port RAM with per-lane writes and a selectable read-during-write policy.
// It zeroes every word after reset, then serves reads with 1 or 2 cycles of latency.
module ram_dp_clr #(
  parameter int WORDSIZE   = 16,
  parameter int ADDRSIZE   = 6,
  parameter int LANE_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RW_MODE    = 0,
  localparam int NLANES    = WORDSIZE / LANE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                rd_en,
  input  logic [ADDRSIZE-1:0] read_addr,
  input  logic                wr_en,
  input  logic [ADDRSIZE-1:0] write_addr,
  input  logic [NLANES-1:0]   lane_en,
  input  logic [WORDSIZE-1:0] data_in,
  output logic [WORDSIZE-1:0] data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int DEPTH = 2 ** ADDRSIZE;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [WORDSIZE-1:0] r_mem [DEPTH];
  logic [0:0]          r_state;
  logic [ADDRSIZE-1:0] r_clr_addr;
  logic [WORDSIZE-1:0] r_dout;
  logic                r_vld;

  logic                w_run;
  logic                w_wr;
  logic                w_rd;
  logic                w_bypass;
  logic [WORDSIZE-1:0] w_rd_mem;
  logic [WORDSIZE-1:0] w_merged;
  logic [WORDSIZE-1:0] w_rd_word;
  logic                w_s_vld;
  logic [WORDSIZE-1:0] w_s_dat;

  assign w_run = (r_state == S_RUN);
  assign w_wr  = cs & wr_en & w_run;
  assign w_rd  = cs & rd_en & w_run;
  assign busy  = ~w_run;

  // Clear sequencer: walks every address once, then hands over to normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDRSIZE'(1);
      if (r_clr_addr == ADDRSIZE'(DEPTH - 1)) r_state <= S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_wr) begin
        for (int i = 0; i < NLANES; i++) begin
          if (lane_en[i]) r_mem[write_addr][i*LANE_W +: LANE_W] <= data_in[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Merged word is what the addressed entry holds once this cycle's write lands.
  always_comb begin
    w_rd_mem = r_mem[read_addr];
    w_merged = w_rd_mem;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_en[i]) w_merged[i*LANE_W +: LANE_W] = data_in[i*LANE_W +: LANE_W];
    end
    w_bypass  = (RW_MODE == 1) && w_wr && (write_addr == read_addr);
    w_rd_word = w_bypass ? w_merged : w_rd_mem;
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                r_p_vld;
      logic [WORDSIZE-1:0] r_p_dat;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_p_vld <= 1'b0;
        end else begin
          r_p_vld <= w_rd;
          if (w_rd) r_p_dat <= w_rd_word;
        end
      end
      assign w_s_vld = r_p_vld;
      assign w_s_dat = r_p_dat;
    end else begin : g_lat1
      assign w_s_vld = w_rd;
      assign w_s_dat = w_rd_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_s_vld;
      if (w_s_vld) r_dout <= w_s_dat;
    end
  end

  assign rd_valid = r_vld;
  assign data_out = cs ? r_dout : {WORDSIZE{1'bz}};

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: defaults, RW_MODE=1 and RD_LATENCY=2 instances share one stimulus.
module tb_ram_dp_clr;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        rd_en;
  logic [5:0]  read_addr;
  logic        wr_en;
  logic [5:0]  write_addr;
  logic [1:0]  lane_en;
  logic [15:0] data_in;

  logic [15:0] d0, d1, d2;
  logic        v0, v1, v2;
  logic        b0, b1, b2;

  int          checks;
  int          errors;
  logic [15:0] zz;

  ram_dp_clr u_dut (
    .clk(clk), .rst(rst), .cs(cs), .rd_en(rd_en), .read_addr(read_addr),
    .wr_en(wr_en), .write_addr(write_addr), .lane_en(lane_en), .data_in(data_in),
    .data_out(d0), .rd_valid(v0), .busy(b0)
  );

  ram_dp_clr #(.RW_MODE(1)) u_rw1 (
    .clk(clk), .rst(rst), .cs(cs), .rd_en(rd_en), .read_addr(read_addr),
    .wr_en(wr_en), .write_addr(write_addr), .lane_en(lane_en), .data_in(data_in),
    .data_out(d1), .rd_valid(v1), .busy(b1)
  );

  ram_dp_clr #(.RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .cs(cs), .rd_en(rd_en), .read_addr(read_addr),
    .wr_en(wr_en), .write_addr(write_addr), .lane_en(lane_en), .data_in(data_in),
    .data_out(d2), .rd_valid(v2), .busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
    lane_en = 2'b00;
    data_in = 16'h0000;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (v0 !== 1'b0 || d0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out got vld=%b dat=%h want vld=0 dat=0000", v0, d0);
    end
    checks++;
    if (b0 !== 1'b1 || b1 !== 1'b1 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy got %b%b%b want 111", b0, b1, b2);
    end
    n = 0;
    while (b0 === 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL clear_cycles got %0d want 64", n);
    end
    checks++;
    if (b1 !== 1'b0 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_busy got %b%b want 00", b1, b2);
    end
  endtask

  task automatic test_clear_contents();
    int bad0, bad2;
    bad0 = 0;
    bad2 = 0;
    for (int a = 0; a <= 64; a++) begin
      rd_en = (a < 64);
      read_addr = 6'(a);
      step();
      if (a < 64 && (v0 !== 1'b1 || d0 !== 16'h0000)) bad0++;
      if (a > 0 && (v2 !== 1'b1 || d2 !== 16'h0000)) bad2++;
    end
    idle();
    checks++;
    if (bad0 !== 0) begin
      errors++;
      $display("FAIL clear_read_lat1 got %0d bad words want 0", bad0);
    end
    checks++;
    if (bad2 !== 0) begin
      errors++;
      $display("FAIL clear_read_lat2 got %0d bad words want 0", bad2);
    end
    step();
    step();
  endtask

  task automatic test_lane_write();
    wr_en = 1'b1;
    write_addr = 6'd5;
    data_in = 16'hABCD;
    lane_en = 2'b11;
    step();
    data_in = 16'h1234;
    lane_en = 2'b01;
    step();
    idle();
    rd_en = 1'b1;
    read_addr = 6'd5;
    step();
    rd_en = 1'b0;
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'hAB34) begin
      errors++;
      $display("FAIL lane_read got vld=%b dat=%h want vld=1 dat=ab34", v0, d0);
    end
    checks++;
    if (v2 !== 1'b0) begin
      errors++;
      $display("FAIL lane_lat2_early got vld=%b want 0", v2);
    end
    step();
    checks++;
    if (v0 !== 1'b0 || d0 !== 16'hAB34) begin
      errors++;
      $display("FAIL lane_hold got vld=%b dat=%h want vld=0 dat=ab34", v0, d0);
    end
    checks++;
    if (v2 !== 1'b1 || d2 !== 16'hAB34) begin
      errors++;
      $display("FAIL lane_lat2 got vld=%b dat=%h want vld=1 dat=ab34", v2, d2);
    end
    step();
  endtask

  task automatic test_rw_collision();
    wr_en = 1'b1;
    write_addr = 6'd9;
    data_in = 16'h5555;
    lane_en = 2'b11;
    rd_en = 1'b1;
    read_addr = 6'd9;
    step();
    idle();
    checks++;
    if (d0 !== 16'h0000) begin
      errors++;
      $display("FAIL rw_mode0 got %h want 0000", d0);
    end
    checks++;
    if (d1 !== 16'h5555) begin
      errors++;
      $display("FAIL rw_mode1 got %h want 5555", d1);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (d0 !== 16'h5555) begin
      errors++;
      $display("FAIL rw_after_write got %h want 5555", d0);
    end
    step();
    step();
  endtask

  task automatic test_latency2();
    wr_en = 1'b1;
    lane_en = 2'b11;
    write_addr = 6'd1; data_in = 16'h1111; step();
    write_addr = 6'd2; data_in = 16'h2222; step();
    write_addr = 6'd3; data_in = 16'h3333; step();
    idle();
    rd_en = 1'b1;
    read_addr = 6'd1;
    step();
    checks++;
    if (v2 !== 1'b0 || d0 !== 16'h1111) begin
      errors++;
      $display("FAIL lat2_first got v2=%b d0=%h want v2=0 d0=1111", v2, d0);
    end
    read_addr = 6'd2;
    step();
    checks++;
    if (v2 !== 1'b1 || d2 !== 16'h1111) begin
      errors++;
      $display("FAIL lat2_r1 got vld=%b dat=%h want vld=1 dat=1111", v2, d2);
    end
    read_addr = 6'd3;
    step();
    rd_en = 1'b0;
    checks++;
    if (v2 !== 1'b1 || d2 !== 16'h2222) begin
      errors++;
      $display("FAIL lat2_r2 got vld=%b dat=%h want vld=1 dat=2222", v2, d2);
    end
    step();
    checks++;
    if (v2 !== 1'b1 || d2 !== 16'h3333) begin
      errors++;
      $display("FAIL lat2_r3 got vld=%b dat=%h want vld=1 dat=3333", v2, d2);
    end
    step();
    checks++;
    if (v2 !== 1'b0 || d2 !== 16'h3333) begin
      errors++;
      $display("FAIL lat2_hold got vld=%b dat=%h want vld=0 dat=3333", v2, d2);
    end
  endtask

  task automatic test_chip_select();
    cs = 1'b0;
    #1;
    checks++;
    if (d0 !== zz || d2 !== zz) begin
      errors++;
      $display("FAIL cs_highz got %h %h want zzzz", d0, d2);
    end
    wr_en = 1'b1;
    write_addr = 6'd5;
    data_in = 16'h0000;
    lane_en = 2'b11;
    rd_en = 1'b1;
    read_addr = 6'd5;
    step();
    idle();
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL cs_read_ignored got vld=%b want 0", v0);
    end
    cs = 1'b1;
    rd_en = 1'b1;
    read_addr = 6'd5;
    step();
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'hAB34) begin
      errors++;
      $display("FAIL cs_write_ignored got vld=%b dat=%h want vld=1 dat=ab34", v0, d0);
    end
    read_addr = 6'd2;
    step();
    rd_en = 1'b0;
    cs = 1'b0;
    step();
    checks++;
    if (v2 !== 1'b1 || d2 !== zz) begin
      errors++;
      $display("FAIL cs_inflight got vld=%b dat=%h want vld=1 dat=zzzz", v2, d2);
    end
    cs = 1'b1;
    #1;
    checks++;
    if (d2 !== 16'h2222) begin
      errors++;
      $display("FAIL cs_return got %h want 2222", d2);
    end
    step();
  endtask

  task automatic test_clear_restart();
    int n;
    wr_en = 1'b1;
    write_addr = 6'd63;
    data_in = 16'hFFFF;
    lane_en = 2'b11;
    step();
    idle();
    rd_en = 1'b1;
    read_addr = 6'd63;
    step();
    rd_en = 1'b0;
    checks++;
    if (d0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL pre_clear got %h want ffff", d0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (b0 !== 1'b1 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got busy=%b vld=%b want busy=1 vld=0", b0, v0);
    end
    rd_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (b0 === 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL restart_cycles got %0d want 64", n);
    end
    rd_en = 1'b1;
    read_addr = 6'd63;
    step();
    rd_en = 1'b0;
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h0000) begin
      errors++;
      $display("FAIL restart_read got vld=%b dat=%h want vld=1 dat=0000", v0, d0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    zz = 'z;
    rst = 1'b0;
    cs = 1'b1;
    read_addr = '0;
    write_addr = '0;
    idle();
    #2;
    test_reset();
    test_clear_contents();
    test_lane_write();
    test_rw_collision();
    test_latency2();
    test_chip_select();
    test_clear_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
